// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: control inputs, instruction-memory port and IF/ID outputs.
// Counter signals exist only when FETCH_PERF_EN is defined.
interface fetch_stage_if #(
  parameter int XLEN = 64
);
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [XLEN-1:0] if_id_pc;
  logic [31:0]     if_id_instr;
  logic            if_id_valid;
  logic [6:0]      opcode;
  logic            misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0]     fetch_count;
  logic [31:0]     bubble_count;
`endif

  modport master (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_addr, if_id_pc, if_id_instr, if_id_valid, opcode, misalign_err
`ifdef FETCH_PERF_EN
    , output fetch_count, bubble_count
`endif
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_addr, if_id_pc, if_id_instr, if_id_valid, opcode, misalign_err
`ifdef FETCH_PERF_EN
    , input fetch_count, bubble_count
`endif
  );
endinterface

// File: rtl/fetch_stage.sv
// PC owner and IF/ID register: one-cycle fetch latency, stall holds everything, redirect inserts one bubble.
// Optional saturating fetch/bubble counters are built when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;
  logic            id_valid;
  logic            misalign;
  logic            advance;

  // Redirect wins over stall, so only an unredirected, unstalled cycle advances.
  assign advance = !bus.branch_taken && !bus.stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      id_pc    <= '0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (bus.branch_taken) begin
      pc       <= {bus.branch_target[XLEN-1:2], 2'b00};
      id_pc    <= pc;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (!bus.stall) begin
      pc       <= pc + XLEN'(4);
      id_pc    <= pc;
      id_instr <= bus.imem_rdata;
      id_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign <= 1'b0;
    end else if (bus.branch_taken && (bus.branch_target[1:0] != 2'b00)) begin
      misalign <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (advance && (fetch_cnt != 32'hFFFF_FFFF)) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (bus.branch_taken && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end

  assign bus.fetch_count  = fetch_cnt;
  assign bus.bubble_count = bubble_cnt;
`endif

  assign bus.imem_addr    = pc;
  assign bus.if_id_pc     = id_pc;
  assign bus.if_id_instr  = id_instr;
  assign bus.if_id_valid  = id_valid;
  assign bus.opcode       = id_instr[6:0];
  assign bus.misalign_err = misalign;
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the 2.5-stage pipeline. It owns the PC and drives the instruction-memory address. It latches each fetched word into the IF/ID register, and that register supplies the opcode to the control unit and the instruction and PC to decode. It handles stall holds, branch redirects with a one-slot flush, and PC wrap-around.

## Interface
- XLEN, 64, PC and address width in bits.
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) inserted on reset and flush.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID contents this cycle.
- branch_taken  input  1  redirect request from the branch-resolve logic.
- branch_target  input  XLEN  redirect address, valid when branch_taken=1.
- imem_addr  output  XLEN  instruction memory address, combinational, equal to the PC register.
- imem_rdata  input  32  instruction word, combinational read of imem_addr in the same cycle.
- if_id_pc  output  XLEN  PC of the held instruction.
- if_id_instr  output  32  held instruction word.
- if_id_valid  output  1  held word is a real fetched instruction (0 = bubble).
- opcode  output  7  if_id_instr[6:0], to the control unit.
- misalign_err  output  1  sticky: a redirect target had bits[1:0] != 0.
- fetch_count  output  32  present only with FETCH_PERF_EN.
- bubble_count  output  32  present only with FETCH_PERF_EN.

## Operation
- Registers:
  - pc
  - if_id_pc
  - if_id_instr
  - if_id_valid
  - misalign_err
  - counters, when configured.
- Values on reset:
  - pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, misalign_err=0, counters=0.
  - opcode therefore reads 7'b0010011.
- Per-cycle priority is reset > branch_taken > stall > normal.
  - **Normal:** if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_valid<=1, pc<=pc+4.
  - **Redirect:** pc<={branch_target[XLEN-1:2],2'b00}, if_id_instr<=NOP_INSTR, if_id_valid<=0. if_id_pc<=pc (don't-care value, but deterministic). Redirect overrides a simultaneous stall.
  - **Stall (no redirect):** pc and all IF/ID registers hold.
- Misalignment: if branch_taken=1 and branch_target[1:0]!=0, misalign_err<=1. The flag stays set until reset. The low bits are still forced to zero.
- Arithmetic: pc+4 is computed modulo 2^XLEN, so pc = 2^XLEN-4 wraps to 0 with no flag.
- Reset asserted mid-stream overrides every other input on that edge. The next IF/ID content is a bubble.
- No state machine beyond valid/bubble. The effective states are:
  - BUBBLE (if_id_valid=0), entered on reset or redirect.
  - VALID (if_id_valid=1), entered on any normal advance.
  - Stall keeps the current state.

## Timing
- Fetch latency is one cycle: a word presented on imem_rdata while pc=A appears on if_id_instr/if_id_pc=A after the next rising edge.
- Redirect penalty is one bubble. If branch_taken is sampled at edge N:
  - edge N: IF/ID becomes a bubble and pc=target.
  - edge N+1: IF/ID holds the instruction at target.
- After reset deasserts, the first edge loads the RESET_PC instruction and pc=RESET_PC+4.
- imem_addr changes only at clock edges. It is glitch-free relative to pc.
- opcode is purely combinational from if_id_instr, with no added latency.

## Configuration
- FETCH_PERF_EN
  - **Defined:**
    - fetch_count increments on every edge that performs a normal advance.
    - bubble_count increments on every edge that inserts a bubble by redirect.
    - Both reset to 0, saturate at 32'hFFFF_FFFF, and hold during stall.
  - **Undefined:** both counters and their ports are absent. All other behaviour is identical.

## Test plan
- **Reset then free-run:** hold reset 2 cycles, RESET_PC=0, imem returns addr-indexed words (0x00000033, 0x00000003, ...) -> cycle after release:
  - if_id_pc=0, if_id_instr=0x00000033, opcode=0110011, valid=1, imem_addr=4.
  - Next cycle: if_id_pc=4, opcode=0000011.
- **Stall:** assert stall 3 cycles at pc=0x10 -> imem_addr stays 0x10 and IF/ID stays unchanged for 3 edges, then advances to pc 0x10.
- **Redirect:** branch_taken=1, target=0x40 at pc=0x08 -> next edge: valid=0, instr=0x00000013, imem_addr=0x40. Following edge: if_id_pc=0x40, valid=1.
- **Redirect during stall, plus misaligned target:** stall=1, branch_taken=1, target=0x42 -> pc=0x40, bubble inserted, misalign_err=1, and misalign_err stays 1 until reset.
- **Wrap and mid-run reset:**
  - Redirect to 0xFFFF_FFFF_FFFF_FFFC, then run -> pc becomes 0 next edge with no error.
  - Assert reset with branch_taken=1 -> pc=RESET_PC, valid=0.
- **FETCH_PERF_EN:** 5 advances, 2 redirects, 3 stalls -> fetch_count=5, bubble_count=2.
